// File: rtl/player_input_router_if.sv
// Player-facing bundle: four raw push-buttons plus menu mode in,
// sticky ready flags, move pulses and the activity strobe out.
interface player_input_router_if;
    logic green_btn;
    logic red_btn;
    logic blue_btn;
    logic yellow_btn;
    logic is_in_menu;

    logic green_ready_to_play;
    logic red_ready_to_play;
    logic blue_ready_to_play;
    logic yellow_ready_to_play;

    logic green_move;
    logic red_move;
    logic blue_move;
    logic yellow_move;

    logic activity;

    modport slave (
        input  green_btn,
        input  red_btn,
        input  blue_btn,
        input  yellow_btn,
        input  is_in_menu,
        output green_ready_to_play,
        output red_ready_to_play,
        output blue_ready_to_play,
        output yellow_ready_to_play,
        output green_move,
        output red_move,
        output blue_move,
        output yellow_move,
        output activity
    );

    modport master (
        output green_btn,
        output red_btn,
        output blue_btn,
        output yellow_btn,
        output is_in_menu,
        input  green_ready_to_play,
        input  red_ready_to_play,
        input  blue_ready_to_play,
        input  yellow_ready_to_play,
        input  green_move,
        input  red_move,
        input  blue_move,
        input  yellow_move,
        input  activity
    );
endinterface

// File: rtl/player_input_router.sv
// Synchronises and debounces the four player buttons and routes each accepted
// press either to a sticky ready flag (menu) or a one-cycle move pulse (race).
module player_input_router #(
    parameter int DEBOUNCE_CLK_COUNT = 500000
) (
    input  logic                  clk,
    input  logic                  reset,
    player_input_router_if.slave  bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CLK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CLK_COUNT - 1);

    // Channel order everywhere: bit 0 green, 1 red, 2 blue, 3 yellow.
    logic [3:0] raw;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] deb;
    logic [3:0] deb_d;
    logic [3:0] press;
    logic [3:0] ready;
    logic [3:0] move;

    assign raw = {bus.yellow_btn, bus.blue_btn, bus.red_btn, bus.green_btn};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A changed level must persist for DEBOUNCE_CLK_COUNT cycles; any return
    // to the accepted level discards the partial count.
    for (genvar i = 0; i < 4; i++) begin : g_chan
        logic [CNT_W-1:0] cnt;
        logic             deb_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt   <= '0;
                deb_q <= 1'b0;
            end else if (sync2[i] == deb_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb_q <= sync2[i];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign deb[i] = deb_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_d <= '0;
            press <= '0;
            ready <= '0;
            move  <= '0;
        end else begin
            deb_d <= deb;
            press <= deb & ~deb_d;
            ready <= ready | (press & {4{bus.is_in_menu}});
            move  <= press & {4{~bus.is_in_menu}};
        end
    end

    assign bus.green_ready_to_play  = ready[0];
    assign bus.red_ready_to_play    = ready[1];
    assign bus.blue_ready_to_play   = ready[2];
    assign bus.yellow_ready_to_play = ready[3];

    assign bus.green_move  = move[0];
    assign bus.red_move    = move[1];
    assign bus.blue_move   = move[2];
    assign bus.yellow_move = move[3];

    assign bus.activity = |press;

endmodule

// File: tb/tb_player_input_router.sv
// Bench for player_input_router: a windowed behavioural model checked every
// cycle, plus hand-computed latency and pulse-count expectations.
module tb_player_input_router;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic       menu;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    player_input_router_if bus();

    assign bus.green_btn  = btn[0];
    assign bus.red_btn    = btn[1];
    assign bus.blue_btn   = btn[2];
    assign bus.yellow_btn = btn[3];
    assign bus.is_in_menu = menu;

    player_input_router #(.DEBOUNCE_CLK_COUNT(DEB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [3:0] ready_o;
    logic [3:0] move_o;
    assign ready_o = {bus.yellow_ready_to_play, bus.blue_ready_to_play,
                      bus.red_ready_to_play, bus.green_ready_to_play};
    assign move_o  = {bus.yellow_move, bus.blue_move, bus.red_move, bus.green_move};

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: debounced level flips when the last DEB synchronised samples all
    // disagree with it; press follows a rise by one cycle, routing one more.
    int         edge_n = 0;
    bit         model_started = 1'b0;
    bit [3:0]   m_s1, m_s, m_deb, m_press, m_ready, m_move;
    bit [DEB-1:0] m_win [4];
    int         rise_edge [4];

    always @(posedge clk) begin
        edge_n++;
        model_started = 1'b1;
        if (reset) begin
            m_s1 = '0; m_s = '0; m_deb = '0;
            m_press = '0; m_ready = '0; m_move = '0;
            for (int i = 0; i < 4; i++) begin
                m_win[i]     = '0;
                rise_edge[i] = -10;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_move[i]  = m_press[i] && !menu;
                m_ready[i] = m_ready[i] | (m_press[i] && menu);
                m_press[i] = (rise_edge[i] == edge_n - 1);
                m_win[i]   = {m_win[i][DEB-2:0], m_s[i]};
                if ((m_deb[i] == 1'b0 && &m_win[i]) || (m_deb[i] == 1'b1 && m_win[i] == '0)) begin
                    m_deb[i] = ~m_deb[i];
                    if (m_deb[i]) rise_edge[i] = edge_n;
                end
            end
            m_s  = m_s1;
            m_s1 = btn;
        end
    end

    int act_cnt = 0;
    int move_cnt [4] = '{0, 0, 0, 0};

    always @(negedge clk) begin
        if (model_started) begin
            checkOutput("ready", 32'(ready_o), 32'(m_ready));
            checkOutput("move", 32'(move_o), 32'(m_move));
            checkOutput("activity", 32'(bus.activity), 32'(|m_press));
            act_cnt += int'(bus.activity);
            for (int i = 0; i < 4; i++) move_cnt[i] += int'(move_o[i]);
        end
    end

    task automatic clearCounters();
        act_cnt = 0;
        for (int i = 0; i < 4; i++) move_cnt[i] = 0;
    endtask

    task automatic applyStimulus(input logic [3:0] b, input logic m, input int n);
        btn  = b;
        menu = m;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        btn   = '0;
        menu  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", 32'(ready_o), 32'h0);
        checkOutput("reset_move", 32'(move_o), 32'h0);
        checkOutput("reset_activity", 32'(bus.activity), 32'h0);
        reset = 1'b0;

        // Green held in menu: ready rises on the 8th edge after first sample.
        clearCounters();
        applyStimulus(4'b0001, 1'b1, 7);
        checkOutput("green_ready_early", 32'(ready_o), 32'h0);
        applyStimulus(4'b0001, 1'b1, 1);
        checkOutput("green_ready_on_time", 32'(ready_o), 32'h1);
        applyStimulus(4'b0001, 1'b1, 4);
        applyStimulus(4'b0000, 1'b1, 10);
        checkOutput("green_activity_count", 32'(act_cnt), 32'd1);
        checkOutput("green_no_move", 32'(move_cnt[0]), 32'd0);

        // Red bounces once; the count restarts from the final rise.
        clearCounters();
        applyStimulus(4'b0010, 1'b1, 3);
        applyStimulus(4'b0000, 1'b1, 1);
        applyStimulus(4'b0010, 1'b1, 7);
        checkOutput("red_ready_early", 32'(ready_o), 32'h1);
        applyStimulus(4'b0010, 1'b1, 1);
        checkOutput("red_ready_on_time", 32'(ready_o), 32'h3);
        applyStimulus(4'b0010, 1'b1, 4);
        applyStimulus(4'b0000, 1'b1, 10);
        checkOutput("red_activity_count", 32'(act_cnt), 32'd1);

        // Blue pressed three times during the race.
        clearCounters();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0100, 1'b0, 6);
            applyStimulus(4'b0000, 1'b0, 6);
        end
        applyStimulus(4'b0000, 1'b0, 10);
        checkOutput("blue_move_count", 32'(move_cnt[2]), 32'd3);
        checkOutput("blue_activity_count", 32'(act_cnt), 32'd3);
        checkOutput("blue_ready_unchanged", 32'(ready_o), 32'h3);

        // Fresh reset, then all four pressed together in menu.
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b1, 2);
        checkOutput("reset2_ready", 32'(ready_o), 32'h0);
        reset = 1'b0;
        clearCounters();
        applyStimulus(4'b1111, 1'b1, 7);
        checkOutput("all_ready_early", 32'(ready_o), 32'h0);
        applyStimulus(4'b1111, 1'b1, 1);
        checkOutput("all_ready_together", 32'(ready_o), 32'hF);
        applyStimulus(4'b1111, 1'b1, 3);
        applyStimulus(4'b0000, 1'b1, 12);
        checkOutput("all_activity_count", 32'(act_cnt), 32'd1);

        // Race starts with yellow already ready; its press becomes a move.
        clearCounters();
        applyStimulus(4'b1000, 1'b0, 8);
        applyStimulus(4'b0000, 1'b0, 12);
        checkOutput("yellow_move_count", 32'(move_cnt[3]), 32'd1);
        checkOutput("yellow_ready_kept", 32'(ready_o), 32'hF);

        // Reset in the middle of a green debounce leaves nothing behind.
        applyStimulus(4'b0001, 1'b0, 4);
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b0, 1);
        checkOutput("midreset_ready", 32'(ready_o), 32'h0);
        checkOutput("midreset_move", 32'(move_o), 32'h0);
        checkOutput("midreset_activity", 32'(bus.activity), 32'h0);
        reset = 1'b0;
        clearCounters();
        applyStimulus(4'b0000, 1'b0, 12);
        checkOutput("no_stale_press", 32'(act_cnt), 32'd0);

        // Long hold in race mode: one move, release is silent.
        clearCounters();
        applyStimulus(4'b0001, 1'b0, 1000);
        checkOutput("long_hold_moves", 32'(move_cnt[0]), 32'd1);
        applyStimulus(4'b0000, 1'b0, 15);
        checkOutput("long_release_moves", 32'(move_cnt[0]), 32'd1);
        checkOutput("long_activity_count", 32'(act_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
